// File: rtl/ysyx_25030081_mc_seq.sv
// Multi-cycle RV32 instruction sequencer: fetch/decode/execute/memory/writeback
// with ifu/lsu handshakes, response timeout and sticky fault halt.
module ysyx_25030081_mc_seq #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  output logic             ir_wen,
  input  logic             dec_reg_wr,
  input  logic             dec_mem_to_reg,
  input  logic             dec_mem_wr,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  output logic             lsu_req_valid,
  output logic             lsu_req_wen,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  output logic             rf_wen,
  output logic             pc_wen,
  output logic             halt,
  output logic             fault,
  output logic [2:0]       fault_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned   TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MREQ   = 3'd4,
    S_MWAIT  = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE    = 3'd0,
    C_FETCH   = 3'd1,
    C_ILLEGAL = 3'd2,
    C_LSU     = 3'd3,
    C_TIMEOUT = 3'd4
  } cause_t;

  state_t           r_state;
  cause_t           r_cause;
  logic             r_fault;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_instret;

  logic w_mem_op;
  logic w_bad_dec;
  logic w_tmo;

  assign w_mem_op  = dec_mem_to_reg | dec_mem_wr;
  assign w_bad_dec = dec_illegal | (dec_mem_to_reg & dec_mem_wr);
  assign w_tmo     = (r_timer == TLIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cause   <= C_NONE;
      r_fault   <= 1'b0;
      r_timer   <= '0;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (ifu_req_ready) begin
            r_state <= S_FWAIT;
            r_timer <= '0;
          end
        end
        S_FWAIT: begin
          // A response in the final timer cycle takes priority over the timeout.
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              r_state <= S_HALT;
              r_fault <= 1'b1;
              r_cause <= C_FETCH;
            end else begin
              r_state <= S_DECODE;
            end
          end else if (w_tmo) begin
            r_state <= S_HALT;
            r_fault <= 1'b1;
            r_cause <= C_TIMEOUT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DECODE: begin
          if (w_bad_dec) begin
            r_state <= S_HALT;
            r_fault <= 1'b1;
            r_cause <= C_ILLEGAL;
          end else if (dec_ebreak) begin
            r_state   <= S_HALT;
            r_instret <= r_instret + CNT_W'(1);
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: r_state <= w_mem_op ? S_MREQ : S_WB;
        S_MREQ: begin
          if (lsu_req_ready) begin
            r_state <= S_MWAIT;
            r_timer <= '0;
          end
        end
        S_MWAIT: begin
          if (lsu_rsp_valid) begin
            if (lsu_rsp_err) begin
              r_state <= S_HALT;
              r_fault <= 1'b1;
              r_cause <= C_LSU;
            end else begin
              r_state <= S_WB;
            end
          end else if (w_tmo) begin
            r_state <= S_HALT;
            r_fault <= 1'b1;
            r_cause <= C_TIMEOUT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + CNT_W'(1);
        end
        S_HALT: r_state <= S_HALT;
      endcase
    end
  end

  // Enables decode from the registered state; ir_wen follows the response in the same cycle.
  always_comb begin
    ifu_req_valid = 1'b0;
    ir_wen        = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    rf_wen        = 1'b0;
    pc_wen        = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: ifu_req_valid = 1'b1;
        S_FWAIT: ir_wen = ifu_rsp_valid & ~ifu_rsp_err;
        S_MREQ: begin
          lsu_req_valid = 1'b1;
          lsu_req_wen   = dec_mem_wr;
        end
        S_WB: begin
          pc_wen = 1'b1;
          rf_wen = dec_reg_wr;
        end
        default: ;
      endcase
    end
  end

  assign halt        = (r_state == S_HALT);
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign state       = r_state;
  assign instret     = r_instret;

endmodule

// File: tb/tb_ysyx_25030081_mc_seq.sv
// Bench for ysyx_25030081_mc_seq: per-instruction expected traces built from
// phase/delay descriptions, a directed table plus randomized instructions.
module tb_ysyx_25030081_mc_seq;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ir_wen;
  logic        dec_reg_wr, dec_mem_to_reg, dec_mem_wr, dec_ebreak, dec_illegal;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic        rf_wen, pc_wen, halt, fault;
  logic [2:0]  fault_cause, state;
  logic [31:0] instret;

  ysyx_25030081_mc_seq #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ir_wen(ir_wen),
    .dec_reg_wr(dec_reg_wr), .dec_mem_to_reg(dec_mem_to_reg), .dec_mem_wr(dec_mem_wr),
    .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt), .fault(fault),
    .fault_cause(fault_cause), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        iv, irw, lv, lw, rfw, pcw, hlt, flt;
    logic [2:0]  cause;
    logic [31:0] n;
  } obs_t;

  // stim: {reg_wr, mem_to_reg, mem_wr, ebreak, illegal,
  //        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err}
  typedef struct {
    obs_t        o;
    logic [10:0] s;
  } cyc_t;

  // kind: 0 alu, 1 load, 2 store, 3 ebreak, 4 illegal, 5 load+store encoding
  typedef struct {
    string nm;
    bit    pre_rst;
    int    kind;
    bit    reg_wr;
    int    f_rdy, f_rsp;
    bit    f_err;
    int    m_rdy, m_rsp;
    bit    m_err;
    int    exp_cyc;
  } vec_t;

  cyc_t        tr[$];
  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_instret;
  logic        m_fault;
  logic [2:0]  m_cause;
  bit          halted;

  function automatic logic [5:0] noise();
    return 6'($urandom);
  endfunction

  function automatic logic [4:0] rnd5();
    return 5'($urandom);
  endfunction

  function automatic vec_t mk(string nm, bit pr, int kind, bit rw, int frdy, int frsp, bit ferr,
                              int mrdy, int mrsp, bit merr, int ec);
    vec_t v;
    v.nm = nm; v.pre_rst = pr; v.kind = kind; v.reg_wr = rw;
    v.f_rdy = frdy; v.f_rsp = frsp; v.f_err = ferr;
    v.m_rdy = mrdy; v.m_rsp = mrsp; v.m_err = merr; v.exp_cyc = ec;
    return v;
  endfunction

  task automatic push(input logic [2:0] st, input logic [10:0] s, input logic iv, irw, lv, lw, rfw, pcw);
    cyc_t c;
    c.s = s;
    c.o = '{st, iv, irw, lv, lw, rfw, pcw, (st == 3'd7), m_fault, m_cause, m_instret};
    tr.push_back(c);
  endtask

  task automatic go_halt(input logic [2:0] c);
    m_fault = (c != 3'd0);
    m_cause = c;
    for (int i = 0; i < 50; i++) push(3'd7, {rnd5(), noise()}, 0, 0, 0, 0, 0, 0);
  endtask

  // Expected trace for one instruction, phase by phase from its handshake delays.
  task automatic build(input vec_t v, output bit hl);
    logic [4:0] d;
    logic [5:0] s;
    d = {v.reg_wr, (v.kind == 1 || v.kind == 5), (v.kind == 2 || v.kind == 5), (v.kind == 3), (v.kind == 4)};
    tr.delete();
    hl = 1'b1;
    for (int i = 0; i <= v.f_rdy; i++) begin
      s = noise(); s[5] = (i == v.f_rdy);
      push(3'd0, {rnd5(), s}, 1, 0, 0, 0, 0, 0);
    end
    if (v.f_rsp >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) begin
        s = noise(); s[4] = 1'b0;
        push(3'd1, {rnd5(), s}, 0, 0, 0, 0, 0, 0);
      end
      go_halt(3'd4);
      return;
    end
    for (int i = 0; i < v.f_rsp; i++) begin
      s = noise(); s[4] = 1'b0;
      push(3'd1, {rnd5(), s}, 0, 0, 0, 0, 0, 0);
    end
    s = noise(); s[4] = 1'b1; s[3] = v.f_err;
    push(3'd1, {rnd5(), s}, 0, !v.f_err, 0, 0, 0, 0);
    if (v.f_err) begin go_halt(3'd1); return; end
    push(3'd2, {d, noise()}, 0, 0, 0, 0, 0, 0);
    if (v.kind >= 4) begin go_halt(3'd2); return; end
    if (v.kind == 3) begin m_instret = m_instret + 1; go_halt(3'd0); return; end
    push(3'd3, {d, noise()}, 0, 0, 0, 0, 0, 0);
    if (v.kind == 1 || v.kind == 2) begin
      for (int i = 0; i <= v.m_rdy; i++) begin
        s = noise(); s[2] = (i == v.m_rdy);
        push(3'd4, {d, s}, 0, 0, 1, (v.kind == 2), 0, 0);
      end
      if (v.m_rsp >= int'(TO)) begin
        for (int i = 0; i < int'(TO); i++) begin
          s = noise(); s[1] = 1'b0;
          push(3'd5, {d, s}, 0, 0, 0, 0, 0, 0);
        end
        go_halt(3'd4);
        return;
      end
      for (int i = 0; i < v.m_rsp; i++) begin
        s = noise(); s[1] = 1'b0;
        push(3'd5, {d, s}, 0, 0, 0, 0, 0, 0);
      end
      s = noise(); s[1] = 1'b1; s[0] = v.m_err;
      push(3'd5, {d, s}, 0, 0, 0, 0, 0, 0);
      if (v.m_err) begin go_halt(3'd3); return; end
    end
    push(3'd6, {d, noise()}, 0, 0, 0, 0, v.reg_wr, 1);
    m_instret = m_instret + 1;
    hl = 1'b0;
  endtask

  task automatic check(input string nm, input obs_t e);
    obs_t a;
    a = '{state, ifu_req_valid, ir_wen, lsu_req_valid, lsu_req_wen & lsu_req_valid,
          rf_wen, pc_wen, halt, fault, fault_cause, instret};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s t=%0t: got st=%0d en=%b flt=%b cause=%0d instret=%0d, want st=%0d en=%b flt=%b cause=%0d instret=%0d",
               nm, $time, a.st, {a.iv, a.irw, a.lv, a.lw, a.rfw, a.pcw, a.hlt}, a.flt, a.cause, a.n,
               e.st, {e.iv, e.irw, e.lv, e.lw, e.rfw, e.pcw, e.hlt}, e.flt, e.cause, e.n);
    end
  endtask

  task automatic drive(input logic [10:0] s);
    {dec_reg_wr, dec_mem_to_reg, dec_mem_wr, dec_ebreak, dec_illegal,
     ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err} = s;
  endtask

  task automatic apply(input string nm, input int lim, input int exp_cyc);
    int got = -1;
    int n;
    n = (lim < tr.size()) ? lim : tr.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      drive(tr[k].s);
      @(negedge clk);
      check(nm, tr[k].o);
      if (got < 0 && (pc_wen || halt)) got = k + 1;
    end
    if (exp_cyc > 0) begin
      n_vec++;
      if (got != exp_cyc) begin
        n_err++;
        $display("FAIL %s latency: got %0d cycles, want %0d", nm, got, exp_cyc);
      end
    end
  endtask

  task automatic do_reset(input string nm);
    obs_t z;
    z = '0;
    rst = 1'b1;
    drive('0);
    #1;
    check(nm, z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(nm, z);
    rst = 1'b0;
    m_instret = '0;
    m_fault   = 1'b0;
    m_cause   = 3'd0;
    halted    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive('0);
    m_instret = '0; m_fault = 1'b0; m_cause = 3'd0; halted = 1'b0;

    //            name        rst kind rw frdy frsp ferr mrdy mrsp merr cycles
    tbl.push_back(mk("addi_a",    1, 0, 1, 0, 0,  0, 0, 0,  0, 5));
    tbl.push_back(mk("addi_b",    0, 0, 1, 0, 0,  0, 0, 0,  0, 5));
    tbl.push_back(mk("addi_c",    0, 0, 1, 0, 0,  0, 0, 0,  0, 5));
    tbl.push_back(mk("ebreak",    0, 3, 0, 0, 0,  0, 0, 0,  0, 4));
    tbl.push_back(mk("load_rdy3", 1, 1, 1, 0, 0,  0, 3, 0,  0, 10));
    tbl.push_back(mk("store",     0, 2, 0, 0, 0,  0, 0, 0,  0, 7));
    tbl.push_back(mk("fetch_last",0, 0, 1, 2, 15, 0, 0, 0,  0, 22));
    tbl.push_back(mk("fetch_tmo", 0, 0, 1, 0, 16, 0, 0, 0,  0, 18));
    tbl.push_back(mk("lsu_err",   1, 1, 1, 0, 0,  0, 0, 2,  1, 9));
    tbl.push_back(mk("illegal",   1, 4, 1, 0, 0,  0, 0, 0,  0, 4));
    tbl.push_back(mk("ld_and_st", 1, 5, 1, 0, 0,  0, 0, 0,  0, 4));
    tbl.push_back(mk("fetch_err", 1, 0, 1, 0, 1,  1, 0, 0,  0, 4));
    tbl.push_back(mk("lsu_tmo",   1, 2, 0, 0, 0,  0, 1, 16, 0, 23));
    tbl.push_back(mk("load_last", 1, 1, 1, 0, 0,  0, 0, 15, 0, 22));

    do_reset("reset_init");
    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset("reset_tbl");
      build(tbl[i], halted);
      apply(tbl[i].nm, 1 << 20, tbl[i].exp_cyc);
    end

    do_reset("reset_rand");
    for (int it = 0; it < 40; it++) begin
      vec_t v;
      int   r;
      if (halted) do_reset("reset_rand");
      r = int'($urandom_range(0, 19));
      v.nm      = "rand";
      v.pre_rst = 1'b0;
      v.kind    = (r < 8) ? 0 : (r < 12) ? 1 : (r < 16) ? 2 : (r == 16) ? 3 : (r == 17) ? 4 : (r == 18) ? 5 : 0;
      v.reg_wr  = 1'($urandom);
      v.f_rdy   = int'($urandom_range(0, 3));
      v.f_rsp   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO)) : int'($urandom_range(0, 3));
      v.f_err   = ($urandom_range(0, 15) == 0);
      v.m_rdy   = int'($urandom_range(0, 3));
      v.m_rsp   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO)) : int'($urandom_range(0, 3));
      v.m_err   = ($urandom_range(0, 15) == 0);
      v.exp_cyc = 0;
      build(v, halted);
      apply(v.nm, 1 << 20, 0);
    end

    // Reset while a load waits for its memory response, then a clean restart.
    do_reset("reset_mid");
    build(mk("pre_addi", 0, 0, 1, 0, 0, 0, 0, 0, 0, 5), halted);
    apply("pre_addi", 1 << 20, 5);
    build(mk("load_mwait", 0, 1, 1, 0, 0, 0, 0, 10, 0, 0), halted);
    apply("load_mwait", 7, 0);
    #2;
    do_reset("reset_in_mwait");
    build(mk("post_addi", 0, 0, 1, 0, 0, 0, 0, 0, 0, 5), halted);
    apply("post_addi", 1 << 20, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_mc_seq.md
Name: ysyx_25030081_mc_seq

Overview:
- Multi-cycle instruction sequencer for the RV32 core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Gates the decoder's static controls (reg_wr, mem_wr, mem_to_reg) into one-shot enables, and runs the valid/ready handshakes to the instruction fetch unit and the load/store unit.
- Detects bus errors, illegal instructions, ebreak and response timeouts, and parks the core in a sticky halt.

Parameters:
- TIMEOUT, 16: max cycles spent waiting for an ifu or lsu response before a timeout fault; must be >= 2.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ifu_req_valid  output  1  fetch request.
- ifu_req_ready  input  1  fetch request accepted.
- ifu_rsp_valid  input  1  fetched instruction valid.
- ifu_rsp_err  input  1  fetch bus error, qualified by ifu_rsp_valid.
- ir_wen  output  1  latch instruction register (one-cycle pulse).
- dec_reg_wr  input  1  decoded: writes rd.
- dec_mem_to_reg  input  1  decoded: load.
- dec_mem_wr  input  1  decoded: store.
- dec_ebreak  input  1  decoded: ebreak.
- dec_illegal  input  1  decoded: unsupported encoding.
- lsu_req_valid  output  1  memory request.
- lsu_req_wen  output  1  1 = store, 0 = load; valid with lsu_req_valid.
- lsu_req_ready  input  1  memory request accepted.
- lsu_rsp_valid  input  1  memory response.
- lsu_rsp_err  input  1  memory bus error, qualified by lsu_rsp_valid.
- rf_wen  output  1  register file write enable (pulse).
- pc_wen  output  1  PC update enable (pulse).
- halt  output  1  core stopped (sticky).
- fault  output  1  halt was caused by an error.
- fault_cause  output  3  0 none, 1 fetch error, 2 illegal, 3 lsu error, 4 timeout.
- state  output  3  current state, for debug.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MREQ=4, MWAIT=5, WB=6, HALT=7.
- Reset (async, rst=1):
  - state=FETCH, instret=0, wait timer=0, halt=0, fault=0, fault_cause=0.
  - All request and enable outputs are forced 0 while rst is high.
- FETCH:
  - ifu_req_valid=1, held until ifu_req_ready is sampled high.
  - Then go to FWAIT with the timer cleared.
- FWAIT (waiting for fetch response):
  - ifu_rsp_valid & ~ifu_rsp_err: ir_wen=1 in that same cycle (combinational), go to DECODE.
  - ifu_rsp_valid & ifu_rsp_err: no ir_wen; go to HALT with fault cause 1.
- DECODE (one cycle), checked in this order:
  - dec_illegal, or dec_mem_to_reg & dec_mem_wr both set: HALT, cause 2.
  - dec_ebreak: instret+1, HALT with fault=0.
  - Otherwise: go to EXEC.
- EXEC (one cycle): go to MREQ if dec_mem_to_reg | dec_mem_wr, else go to WB.
- MREQ:
  - lsu_req_valid=1 and lsu_req_wen=dec_mem_wr, both held stable until lsu_req_ready.
  - Then go to MWAIT with the timer cleared.
- MWAIT (waiting for memory response):
  - lsu_rsp_valid & ~lsu_rsp_err: go to WB.
  - lsu_rsp_valid & lsu_rsp_err: HALT, cause 3.
- WB (one cycle): pc_wen=1, rf_wen=dec_reg_wr, instret+1 (wraps modulo 2^CNT_W), go to FETCH.
- Timeout:
  - In FWAIT and MWAIT the timer counts up once per cycle without a response.
  - When the timer equals TIMEOUT-1 and no response arrives that cycle, go to HALT with cause 4.
  - A response arriving in the same cycle the limit is reached wins; no fault is raised.
- Ignored inputs:
  - ready/rsp inputs are ignored outside their owning state.
  - Spurious responses in other states have no effect.
- HALT:
  - Absorbing state; only rst exits it.
  - halt=1; fault and fault_cause hold their captured values.
  - All enables and requests are 0.
- Latency, zero-wait memories:
  - ALU instruction: 5 cycles fetch-request to pc_wen.
  - Load or store: 7 cycles.
- Decoder inputs must be stable from DECODE through WB; they are driven from the latched IR.
- Reset asserted mid-operation:
  - Outstanding requests are abandoned immediately.
  - The sequencer restarts at FETCH after rst deasserts.

Test Plan:
- addi with ifu and lsu ready, responses after 1 cycle → state sequence 0,1,2,3,6,0; ir_wen pulses once; rf_wen=1 and pc_wen=1 in WB; instret=1.
- Load (mem_to_reg=1, reg_wr=1), lsu_req_ready delayed 3 cycles → lsu_req_valid=1 and lsu_req_wen=0 held for 4 cycles; rf_wen=1 in WB; 10 cycles total.
- Store (mem_wr=1, reg_wr=0) → lsu_req_wen=1; WB has rf_wen=0 and pc_wen=1; instret increments.
- ifu_rsp_valid never asserted, TIMEOUT=16 → HALT 16 cycles after entering FWAIT; fault=1, fault_cause=4; stays in HALT for 50 more cycles.
- ifu_rsp_valid in the timer's final cycle → no fault, DECODE next. Separately, lsu_rsp_err=1 → fault_cause=3, rf_wen never asserted.
- ebreak after 3 retired addi → halt=1, fault=0, instret=4. Then pulse rst mid-MWAIT on a later run → state=FETCH, instret=0, lsu_req_valid=0.
